// File: rtl/hz_pkg.sv
// Shared constants and MDU state encoding for the
// pipeline hazard controller.
package hz_pkg;

   localparam int HZ_TW          = 3;
   localparam int HZ_MULT_CYCLES = 5;
   localparam int HZ_DIV_CYCLES  = 10;
   localparam int HZ_CNT_W       = 32;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D/E/M stage hazard inputs and stall/flush
// outputs bundled between pipeline and controller.
interface pipe_hazard_ctrl_if #(
   parameter int TW    = 3,
   parameter int CNT_W = 32
);

   logic             ifReGrf1_D;
   logic             ifReGrf2_D;
   logic [4:0]       grfRa1_D;
   logic [4:0]       grfRa2_D;
   logic [TW-1:0]    tUseRs_D;
   logic [TW-1:0]    tUseRt_D;
   logic             ifWrGrf_E;
   logic [4:0]       grfWa_E;
   logic [TW-1:0]    tNew_E;
   logic             ifWrGrf_M;
   logic [4:0]       grfWa_M;
   logic [TW-1:0]    tNew_M;
   logic             mdUse_D;
   logic             mdStart_E;
   logic             mdIsDiv_E;
   logic             stall_D;
   logic             flush_E;
   logic             mdBusy;
   logic [CNT_W-1:0] stallCnt;
   logic             mdOverlap;

   modport master (
      output ifReGrf1_D, ifReGrf2_D,
      output grfRa1_D, grfRa2_D,
      output tUseRs_D, tUseRt_D,
      output ifWrGrf_E, grfWa_E, tNew_E,
      output ifWrGrf_M, grfWa_M, tNew_M,
      output mdUse_D, mdStart_E, mdIsDiv_E,
      input  stall_D, flush_E, mdBusy,
      input  stallCnt, mdOverlap
   );

   modport slave (
      input  ifReGrf1_D, ifReGrf2_D,
      input  grfRa1_D, grfRa2_D,
      input  tUseRs_D, tUseRt_D,
      input  ifWrGrf_E, grfWa_E, tNew_E,
      input  ifWrGrf_M, grfWa_M, tNew_M,
      input  mdUse_D, mdStart_E, mdIsDiv_E,
      output stall_D, flush_E, mdBusy,
      output stallCnt, mdOverlap
   );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: counts down the MDU latency
// after an E-stage launch and flags overlapping starts.
module md_busy_timer
   import hz_pkg::*;
#(
   parameter int MULT_CYCLES = HZ_MULT_CYCLES,
   parameter int DIV_CYCLES  = HZ_DIV_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic overlap
);

   localparam int MAXC =
      (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   md_state_e      state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           ovl_n;
   logic [CW-1:0]  len;

   assign len = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         overlap <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         overlap <= ovl_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ovl_n   = overlap;
      unique case (state)
         MD_IDLE: begin
            if (start) begin
               state_n = MD_BUSY;
               cnt_n   = len;
            end
         end
         MD_BUSY: begin
            // a restart reloads with the new op length
            if (start) begin
               ovl_n = 1'b1;
               cnt_n = len;
            end else if (cnt == CW'(1)) begin
               state_n = MD_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = MD_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign busy = reset_n & ((state == MD_BUSY) | start);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: tUse/tNew register hazards,
// MDU busy stalls and a stall-cycle counter.
module pipe_hazard_ctrl
   import hz_pkg::*;
#(
   parameter int TW          = HZ_TW,
   parameter int MULT_CYCLES = HZ_MULT_CYCLES,
   parameter int DIV_CYCLES  = HZ_DIV_CYCLES,
   parameter int CNT_W       = HZ_CNT_W
) (
   input logic               clk,
   input logic               reset_n,
   pipe_hazard_ctrl_if.slave hz
);

   logic rs_e, rs_m, rt_e, rt_m;
   logic rs_hz, rt_hz, md_hz;
   logic md_busy, stall;
   logic [CNT_W-1:0] stall_cnt;

   always_comb begin
      rs_e = hz.ifWrGrf_E && (hz.grfWa_E == hz.grfRa1_D)
          && (hz.tNew_E > hz.tUseRs_D);
      rs_m = hz.ifWrGrf_M && (hz.grfWa_M == hz.grfRa1_D)
          && (hz.tNew_M > hz.tUseRs_D);
      rt_e = hz.ifWrGrf_E && (hz.grfWa_E == hz.grfRa2_D)
          && (hz.tNew_E > hz.tUseRt_D);
      rt_m = hz.ifWrGrf_M && (hz.grfWa_M == hz.grfRa2_D)
          && (hz.tNew_M > hz.tUseRt_D);
      // $0 is hardwired, so it never carries a dependency
      rs_hz = hz.ifReGrf1_D && (hz.grfRa1_D != 5'd0)
           && (rs_e || rs_m);
      rt_hz = hz.ifReGrf2_D && (hz.grfRa2_D != 5'd0)
           && (rt_e || rt_m);
      md_hz = hz.mdUse_D && md_busy;
   end

   assign stall = reset_n & (rs_hz | rt_hz | md_hz);

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (hz.mdStart_E),
      .is_div  (hz.mdIsDiv_E),
      .busy    (md_busy),
      .overlap (hz.mdOverlap)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign hz.stall_D  = stall;
   assign hz.flush_E  = stall;
   assign hz.mdBusy   = md_busy;
   assign hz.stallCnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: hazard
// vector table plus MDU timing sequences.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset_n;

   pipe_hazard_ctrl_if #(.TW(3), .CNT_W(32)) hz ();

   pipe_hazard_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       re1;
      logic       re2;
      logic [4:0] ra1;
      logic [4:0] ra2;
      logic [2:0] tu_rs;
      logic [2:0] tu_rt;
      logic       we_e;
      logic [4:0] wa_e;
      logic [2:0] tn_e;
      logic       we_m;
      logic [4:0] wa_m;
      logic [2:0] tn_m;
      logic       md_use;
      logic       exp;
   } vec_t;

   vec_t  vt[12];
   logic  q[$];
   int    checks;
   int    errors;
   int    exp_cnt;
   logic  e;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp_v);
      end
   endtask

   task automatic idle_inputs();
      hz.ifReGrf1_D = 1'b0;
      hz.ifReGrf2_D = 1'b0;
      hz.grfRa1_D   = 5'd0;
      hz.grfRa2_D   = 5'd0;
      hz.tUseRs_D   = 3'd0;
      hz.tUseRt_D   = 3'd0;
      hz.ifWrGrf_E  = 1'b0;
      hz.grfWa_E    = 5'd0;
      hz.tNew_E     = 3'd0;
      hz.ifWrGrf_M  = 1'b0;
      hz.grfWa_M    = 5'd0;
      hz.tNew_M     = 3'd0;
      hz.mdUse_D    = 1'b0;
      hz.mdStart_E  = 1'b0;
      hz.mdIsDiv_E  = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      hz.ifReGrf1_D = v.re1;
      hz.ifReGrf2_D = v.re2;
      hz.grfRa1_D   = v.ra1;
      hz.grfRa2_D   = v.ra2;
      hz.tUseRs_D   = v.tu_rs;
      hz.tUseRt_D   = v.tu_rt;
      hz.ifWrGrf_E  = v.we_e;
      hz.grfWa_E    = v.wa_e;
      hz.tNew_E     = v.tn_e;
      hz.ifWrGrf_M  = v.we_m;
      hz.grfWa_M    = v.wa_m;
      hz.tNew_M     = v.tn_m;
      hz.mdUse_D    = v.md_use;
      hz.mdStart_E  = 1'b0;
      hz.mdIsDiv_E  = 1'b0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;

      // re1 re2 ra1 ra2 turs turt weE waE tnE weM waM tnM md exp
      // lw $1 in E, add reads $1
      vt[0]  = '{1, 0, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 1};
      // lw moved to M, tNew_M=1 no longer beats tUse=1
      vt[1]  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
      // $0 never hazards
      vt[2]  = '{1, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0};
      // rt vs M
      vt[3]  = '{0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 7, 1, 0, 1};
      // E and M both write $5 with tNew=0
      vt[4]  = '{0, 1, 0, 5, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0};
      // rs not read
      vt[5]  = '{0, 0, 3, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0};
      // E does not write
      vt[6]  = '{1, 0, 3, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      // index mismatch
      vt[7]  = '{1, 0, 3, 0, 0, 0, 1, 4, 2, 1, 9, 2, 0, 0};
      // unsigned compare high values
      vt[8]  = '{1, 0, 31, 0, 6, 0, 1, 31, 7, 0, 0, 0, 0, 1};
      // equal tNew/tUse
      vt[9]  = '{1, 0, 9, 0, 3, 0, 1, 9, 3, 0, 0, 0, 0, 0};
      // md use while MDU idle
      vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      // rs and rt both hazard
      vt[11] = '{1, 1, 2, 4, 0, 1, 1, 2, 1, 1, 4, 2, 0, 1};

      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 32'(hz.stall_D), 32'd0);
      chk("rst_busy", 32'(hz.mdBusy), 32'd0);
      chk("rst_cnt", hz.stallCnt, 32'd0);
      chk("rst_ovl", 32'(hz.mdOverlap), 32'd0);
      hz.mdStart_E = 1'b1;
      hz.mdUse_D   = 1'b1;
      #1;
      chk("rst_busy_forced", 32'(hz.mdBusy), 32'd0);
      chk("rst_stall_forced", 32'(hz.stall_D), 32'd0);
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         apply(vt[i]);
         q.push_back(vt[i].exp);
         #1;
         e = q.pop_front();
         chk($sformatf("vec%0d_stall", i),
             32'(hz.stall_D), 32'(e));
         chk($sformatf("vec%0d_flush", i),
             32'(hz.flush_E), 32'(e));
         chk($sformatf("vec%0d_cnt", i),
             hz.stallCnt, 32'(exp_cnt));
         if (e) exp_cnt++;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      chk("vec_cnt_final", hz.stallCnt, 32'(exp_cnt));

      // mult start with mflo waiting in D
      @(negedge clk);
      hz.mdStart_E = 1'b1;
      hz.mdIsDiv_E = 1'b0;
      hz.mdUse_D   = 1'b1;
      for (int i = 0; i < 8; i++) q.push_back(i < 6);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            @(negedge clk);
            hz.mdStart_E = 1'b0;
         end
         #1;
         e = q.pop_front();
         chk($sformatf("mult%0d_busy", i),
             32'(hz.mdBusy), 32'(e));
         chk($sformatf("mult%0d_stall", i),
             32'(hz.stall_D), 32'(e));
      end
      exp_cnt += 6;
      chk("mult_cnt", hz.stallCnt, 32'(exp_cnt));
      hz.mdUse_D = 1'b0;

      // div start, reset at third BUSY cycle
      @(negedge clk);
      hz.mdStart_E = 1'b1;
      hz.mdIsDiv_E = 1'b1;
      hz.mdUse_D   = 1'b1;
      @(negedge clk);
      hz.mdStart_E = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("div_busy_pre", 32'(hz.mdBusy), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("div_rst_busy", 32'(hz.mdBusy), 32'd0);
      chk("div_rst_stall", 32'(hz.stall_D), 32'd0);
      chk("div_rst_cnt", hz.stallCnt, 32'd0);
      hz.mdUse_D = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("div_post%0d_busy", i),
             32'(hz.mdBusy), 32'd0);
      end

      // div start overlapping a running mult
      @(negedge clk);
      for (int i = 0; i < 16; i++) q.push_back(i < 13);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         hz.mdStart_E = (i == 0) || (i == 2);
         hz.mdIsDiv_E = (i == 2);
         #1;
         e = q.pop_front();
         chk($sformatf("ovl%0d_busy", i),
             32'(hz.mdBusy), 32'(e));
         if (i == 1)
            chk("ovl_pre", 32'(hz.mdOverlap), 32'd0);
      end
      chk("ovl_set", 32'(hz.mdOverlap), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("ovl_sticky", 32'(hz.mdOverlap), 32'd1);
      chk("ovl_cnt", hz.stallCnt, 32'(exp_cnt));
      reset_n = 1'b0;
      #1;
      chk("ovl_clear", 32'(hz.mdOverlap), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
